// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter: one holding register per execution unit,
// at most one grant per cycle, registered CDB broadcast.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(NUM_REQ)-1:0] cdb_src
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] hold_valid_q, hold_valid_d;
    logic [TAG_W-1:0]   hold_tag_q  [NUM_REQ];
    logic [TAG_W-1:0]   hold_tag_d  [NUM_REQ];
    logic [DATA_W-1:0]  hold_data_q [NUM_REQ];
    logic [DATA_W-1:0]  hold_data_d [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [PTR_W-1:0]   cdb_src_q, cdb_src_d;

    logic [NUM_REQ-1:0] grant_s;
    logic [NUM_REQ-1:0] accept_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic               grant_any_s;

    // (base + off) mod NUM_REQ, with off < NUM_REQ so one subtraction suffices
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NUM_REQ)) begin
            sum = sum - 32'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    // Round-robin search; scanning downward lets the nearest index to rr_ptr win
    always_comb begin
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            grant_idx_s = hold_valid_q[wrap_idx(rr_ptr_q, k)] ? wrap_idx(rr_ptr_q, k) : grant_idx_s;
            grant_any_s = grant_any_s | hold_valid_q[wrap_idx(rr_ptr_q, k)];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_s[i] = grant_any_s && (grant_idx_s == PTR_W'(i));
        end
    end

    assign req_ready = reset ? (~hold_valid_q | grant_s) : {NUM_REQ{1'b0}};
    assign accept_s  = req_valid & req_ready;

    // Next state: accepts overwrite a releasing hold so a lone unit streams at full rate
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_tag_d   = hold_tag_q;
        hold_data_d  = hold_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept_s[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_tag_d[i]   = req_tag[i*TAG_W +: TAG_W];
                hold_data_d[i]  = req_data[i*DATA_W +: DATA_W];
            end else if (grant_s[i]) begin
                hold_valid_d[i] = 1'b0;
            end else begin
                hold_valid_d[i] = hold_valid_q[i];
            end
        end
        if (grant_any_s) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = hold_tag_q[grant_idx_s];
            cdb_data_d  = hold_data_q[grant_idx_s];
            cdb_src_d   = grant_idx_s;
            rr_ptr_d    = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + PTR_W'(1);
        end else begin
            cdb_valid_d = 1'b0;
            cdb_tag_d   = cdb_tag_q;
            cdb_data_d  = cdb_data_q;
            cdb_src_d   = cdb_src_q;
            rr_ptr_d    = rr_ptr_q;
        end
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_tag_q[i]  <= '0;
                hold_data_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_tag_q   <= hold_tag_d;
            hold_data_q  <= hold_data_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule
